// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Microcode sequencer for a small 8-bit accumulator CPU. It steps through
//   microsteps 0..4 and produces the control word that strobes the register
//   loads and enables.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | stepping through fetch (0,1) and execute (2..4) microsteps
//   HALTED  | HLT executed; o_ctrl pinned to HLT, only reset leaves
//
// Ports
//   i_clk      system clock, all state updates on the rising edge
//   i_rst      synchronous, active-high reset
//   i_run      step enable; low freezes the step and blanks o_ctrl
//   i_opcode   instruction register high nibble, decoded live
//   i_flag_c   carry flag, used by JC at step 2
//   i_flag_z   zero flag, used by JZ at step 2
//   o_ctrl     control word {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
//   o_step     current microstep 0..4
//   o_halted   high while HALTED
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned EARLY_END = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [3:0]  i_opcode,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output logic [15:0] o_ctrl,
  output logic [2:0]  o_step,
  output logic        o_halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_step;
  logic [15:0] w_word;
  logic [2:0]  w_next_step;
  logic        w_early;

  // Microcode decode for the current step; not gated by i_run or state.
  always_comb begin
    w_word = 16'h0000;
    case (r_step)
      3'd0: w_word = C_CO | C_MI;
      3'd1: w_word = C_RO | C_II | C_CE;
      3'd2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_word = C_IO | C_MI;
          OP_LDI: w_word = C_IO | C_AI;
          OP_JMP: w_word = C_IO | C_J;
          OP_JC:  w_word = i_flag_c ? (C_IO | C_J) : 16'h0000;
          OP_JZ:  w_word = i_flag_z ? (C_IO | C_J) : 16'h0000;
          OP_OUT: w_word = C_AO | C_OI;
          OP_HLT: w_word = C_HLT;
          default: w_word = 16'h0000;
        endcase
      end
      3'd3: begin
        case (i_opcode)
          OP_LDA:         w_word = C_RO | C_AI;
          OP_ADD, OP_SUB: w_word = C_RO | C_BI;
          OP_STA:         w_word = C_AO | C_RI;
          default:        w_word = 16'h0000;
        endcase
      end
      3'd4: begin
        case (i_opcode)
          OP_ADD:  w_word = C_EO | C_AI | C_FI;
          OP_SUB:  w_word = C_EO | C_AI | C_SU | C_FI;
          default: w_word = 16'h0000;
        endcase
      end
      default: w_word = 16'h0000;
    endcase
  end

  // An empty execute step means the instruction has nothing left to do.
  assign w_early = (EARLY_END != 0) && (r_step >= 3'd2) && (w_word == 16'h0000);

  always_comb begin
    w_next_step = r_step + 3'd1;
    if (r_step >= LAST_STEP || w_early) begin
      w_next_step = 3'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_step  <= 3'd0;
    end else if (r_state == ST_RUN && i_run) begin
      if (w_word[15]) begin
        // Step is held so the halt point stays visible on o_step.
        r_state <= ST_HALTED;
      end else begin
        r_step <= w_next_step;
      end
    end
  end

  always_comb begin
    o_ctrl = 16'h0000;
    if (r_state == ST_HALTED) begin
      o_ctrl = C_HLT;
    end else if (i_run) begin
      o_ctrl = w_word;
    end
  end

  assign o_step   = r_step;
  assign o_halted = (r_state == ST_HALTED);

endmodule
